// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue controller: ALU op codes, RV64I opcode/funct fields, FSM states.
// No logic; the only function resolves branch direction from the captured ALU flags.
// Optional feature macro BRANCH_EXT_EN is consumed by alu_op_decode, not here.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // How a branch turns the ALU result into taken/not-taken.
    typedef enum logic [1:0] {
        BR_EQ = 2'd0,   // taken when the SUB result is zero
        BR_NE = 2'd1,   // taken when the SUB result is non-zero
        BR_LT = 2'd2,   // taken when SLT returned 1
        BR_GE = 2'd3    // taken when SLT returned 0
    } br_kind_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    function automatic logic br_resolve(input br_kind_e kind, input logic zflag, input logic lsb);
        logic taken;
        case (kind)
            BR_EQ:   taken = zflag;
            BR_NE:   taken = !zflag;
            BR_LT:   taken = lsb;
            default: taken = !lsb;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7 into ALU op, operand selection and branch kind.
// Zero latency; purely combinational.
// No backpressure. With BRANCH_EXT_EN defined, BLT/BGE/BLTU/BGEU decode; otherwise they are illegal.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_e    alu_op,
    output logic       use_imm,
    output logic       flip_sign,
    output logic       is_branch,
    output br_kind_e   br_kind,
    output logic       illegal
);

    // Decode table; anything not matched explicitly stays illegal.
    always_comb begin
        alu_op    = ALU_ADD;
        use_imm   = 1'b0;
        flip_sign = 1'b0;
        is_branch = 1'b0;
        br_kind   = BR_EQ;
        illegal   = 1'b1;
        case (opcode)
            OPC_OP: begin
                case (funct3)
                    F3_ADD: begin
                        if (funct7 == F7_BASE) begin
                            alu_op  = ALU_ADD;
                            illegal = 1'b0;
                        end else if (funct7 == F7_ALT) begin
                            alu_op  = ALU_SUB;
                            illegal = 1'b0;
                        end
                    end
                    F3_AND: begin
                        alu_op  = ALU_AND;
                        illegal = (funct7 != F7_BASE);
                    end
                    F3_OR: begin
                        alu_op  = ALU_OR;
                        illegal = (funct7 != F7_BASE);
                    end
                    F3_SLT: begin
                        alu_op    = ALU_SLT;
                        flip_sign = 1'b1;
                        illegal   = (funct7 != F7_BASE);
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                use_imm = 1'b1;
                illegal = 1'b0;
                case (funct3)
                    F3_ADD: alu_op = ALU_ADD;
                    F3_AND: alu_op = ALU_AND;
                    F3_OR:  alu_op = ALU_OR;
                    F3_SLT: begin
                        alu_op    = ALU_SLT;
                        flip_sign = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                // Address generation only: rs1 + imm.
                alu_op  = ALU_ADD;
                use_imm = 1'b1;
                illegal = 1'b0;
            end
            OPC_BRANCH: begin
                is_branch = 1'b1;
                illegal   = 1'b0;
                case (funct3)
                    F3_BEQ: begin
                        alu_op  = ALU_SUB;
                        br_kind = BR_EQ;
                    end
                    F3_BNE: begin
                        alu_op  = ALU_SUB;
                        br_kind = BR_NE;
                    end
`ifdef BRANCH_EXT_EN
                    F3_BLT: begin
                        alu_op    = ALU_SLT;
                        flip_sign = 1'b1;
                        br_kind   = BR_LT;
                    end
                    F3_BGE: begin
                        alu_op    = ALU_SLT;
                        flip_sign = 1'b1;
                        br_kind   = BR_GE;
                    end
                    F3_BLTU: begin
                        alu_op  = ALU_SLT;
                        br_kind = BR_LT;
                    end
                    F3_BGEU: begin
                        alu_op  = ALU_SLT;
                        br_kind = BR_GE;
                    end
`endif
                    default: begin
                        is_branch = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage driver for an external combinational 64-bit ALU; returns tagged result/zero/branch-taken.
// Legal: operands issued at accept edge N, ALU sampled at N+1, response valid after N+1. Illegal: response after N.
// One op in flight; req_ready only in IDLE, response held stable until rsp_ready. Optional macro: BRANCH_EXT_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_opcode,
    input  logic [2:0]       req_funct3,
    input  logic [6:0]       req_funct7,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [XLEN-1:0]  req_imm,
    input  logic [TAG_W-1:0] req_tag,
    output logic [3:0]       alu_op,
    output logic [XLEN-1:0]  alu_in1,
    output logic [XLEN-1:0]  alu_in2,
    input  logic [XLEN-1:0]  alu_out,
    input  logic             alu_zflag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_result,
    output logic             rsp_zero,
    output logic             rsp_br_taken,
    output logic             rsp_illegal,
    output logic [TAG_W-1:0] rsp_tag
);

    // Inverting the MSB maps signed order onto the ALU's unsigned compare.
    localparam logic [XLEN-1:0] SIGN_BIT = {1'b1, {(XLEN-1){1'b0}}};

    state_e     state;
    state_e     state_next;
    logic       accept;

    alu_op_e    dec_op;
    logic       dec_use_imm;
    logic       dec_flip;
    logic       dec_branch;
    br_kind_e   dec_br_kind;
    logic       dec_illegal;

    alu_op_e    alu_op_q;
    logic       is_branch_q;
    br_kind_e   br_kind_q;
    logic [XLEN-1:0] sign_mask;

    alu_op_decode u_decode (
        .opcode    (req_opcode),
        .funct3    (req_funct3),
        .funct7    (req_funct7),
        .alu_op    (dec_op),
        .use_imm   (dec_use_imm),
        .flip_sign (dec_flip),
        .is_branch (dec_branch),
        .br_kind   (dec_br_kind),
        .illegal   (dec_illegal)
    );

    assign sign_mask = dec_flip ? SIGN_BIT : '0;
    assign alu_op    = alu_op_q;

    // State register; reset drops any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = dec_illegal ? RESP : EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ALU issue registers; loaded only for legal requests, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_q    <= ALU_AND;
            alu_in1     <= '0;
            alu_in2     <= '0;
            is_branch_q <= 1'b0;
            br_kind_q   <= BR_EQ;
        end else if (accept && !dec_illegal) begin
            alu_op_q    <= dec_op;
            alu_in1     <= req_rs1 ^ sign_mask;
            alu_in2     <= (dec_use_imm ? req_imm : req_rs2) ^ sign_mask;
            is_branch_q <= dec_branch;
            br_kind_q   <= dec_br_kind;
        end
    end

    // Response registers: tag at accept, result at EXEC (or zeroed at accept for illegal ops).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_br_taken <= 1'b0;
            rsp_illegal  <= 1'b0;
            rsp_tag      <= '0;
        end else if (accept) begin
            rsp_tag <= req_tag;
            if (dec_illegal) begin
                rsp_result   <= '0;
                rsp_zero     <= 1'b0;
                rsp_br_taken <= 1'b0;
                rsp_illegal  <= 1'b1;
            end
        end else if (state == EXEC) begin
            rsp_result   <= alu_out;
            rsp_zero     <= alu_zflag;
            rsp_br_taken <= is_branch_q && br_resolve(br_kind_q, alu_zflag, alu_out[0]);
            rsp_illegal  <= 1'b0;
        end
    end

endmodule
